router_output_scheduler: RTL and testbench
==========================================

Name: router_output_scheduler

Overview:
Per-output-port scheduler for the lookahead router. It shares one output link among NUM_INPUTS input buffers using round-robin wormhole arbitration, gated by credit-based flow control toward the downstream router. It drives the output crossbar mux select and the per-input dequeue strobes, and it tracks downstream buffer credits. One instance sits beside each output port's crossbar mux.

Parameters:
NUM_INPUTS, 4, number of input ports competing for this output.
CREDITS, 8, downstream input-buffer depth in flits; also the credit count at reset.
CREDIT_W, $clog2(CREDITS+1), width of the credit counter.

Ports:
clk  input  1  clock.
rst_n  input  1  reset; one clock, asynchronous, active-low.
req_valid  input  NUM_INPUTS  input i holds a flit routed to this output at its buffer head.
req_head  input  NUM_INPUTS  flit at input i's buffer head is a head flit.
req_tail  input  NUM_INPUTS  flit at input i's buffer head is a tail flit; head and tail together mean a single-flit packet.
credit_in  input  1  downstream freed one buffer slot this cycle.
sel  output  NUM_INPUTS  one-hot or zero crossbar select.
pop  output  NUM_INPUTS  one-hot or zero dequeue strobe; a flit transfers this cycle.
out_valid  output  1  flit is driven on the output link this cycle; equals |pop.
credits  output  CREDIT_W  current registered credit count.
busy  output  1  state is ACTIVE.
err_credit_ovf  output  1  sticky flag: credit_in was received while credits==CREDITS.

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - state=IDLE, owner=0, credits=CREDITS, err_credit_ovf=0.
  - Round-robin pointer last=NUM_INPUTS-1, so input 0 has highest priority.
  - While rst_n is low, sel, pop and out_valid are forced to 0.
- Grant has zero-cycle latency: sel, pop and out_valid are combinational from req_* and registered state.
- can_send = (credits != 0). credit_in is not usable in the same cycle it arrives.
- State IDLE:
  - Candidates: req_valid[i] & req_head[i].
  - Winner: the first candidate scanning from last+1 upward with wrap-around.
  - If a winner exists and can_send: sel=pop=onehot(winner), out_valid=1.
    - If req_tail[winner]: stay IDLE, last<=winner.
    - Else: go to ACTIVE, owner<=winner.
  - If a winner exists but credits==0: sel=onehot(winner), pop=0, out_valid=0, state unchanged, no lock taken.
  - Non-head flits presented in IDLE are ignored.
- State ACTIVE (locked to owner):
  - sel=onehot(owner) every cycle; all other requests are ignored.
  - If req_valid[owner] & can_send: pop[owner]=1, out_valid=1.
    - If req_tail[owner]: go to IDLE, last<=owner.
  - If req_valid[owner]=0 or credits==0: bubble with pop=0 and the lock held.
  - req_head asserted on the owner mid-packet is a protocol error upstream; treat that flit as a body flit.
- Credit counter: credits_next = credits - out_valid + credit_in.
  - A send and a credit_in in the same cycle leave the count unchanged.
  - credit_in with credits==CREDITS and no send: count saturates at CREDITS and err_credit_ovf<=1 (sticky until reset).
  - Underflow is impossible because sending requires credits!=0.
- busy = (state==ACTIVE).
- Reset mid-packet drops the lock and restores credits. Upstream and downstream are reset together.
- Invariants for the verification engineer:
  - $onehot0(pop), $onehot0(sel), and pop is a subset of sel.
  - credits<=CREDITS at all times.
  - In ACTIVE, sel is stable until the tail is popped.
  - Each pop decrements credits unless credit_in is asserted in the same cycle.

Decomposition:
- Package router_pkg holds:
  - NUM_PORTS and the default CREDITS value.
  - sched_state_t enum {IDLE, ACTIVE}.
  - Helper function rr_pick(candidates, last), which returns the winner index and a found bit.
- Sub-module router_credit_counter, parameterised by CREDITS. Ports: clk, rst_n, consume, credit_in, credits, can_send, err_ovf. The scheduler instantiates it once.
- The FSM, round-robin logic and output muxing live in the top module.

Test Plan:
1. After reset, req_valid=4'b1111, req_head=4'b1111, req_tail=4'b1111, credits=8 → cycle 1 pop=0001. Holding the requests, the following cycles pop 0010, 0100, 1000, then 0001; credits go 8→7→6→5→4 with no credit_in.
2. Input 2 sends head, 3 body flits, tail; input 0 keeps a head pending throughout → sel=0100 for all 5 flits, busy=1 from cycle 2 to the tail. After the tail, input 0 is granted next.
3. CREDITS=8, continuous 10-flit packet from input 1, no credit_in → 8 pops, then credits=0 and pop=0 with sel=0010 held. One credit_in → the next cycle pops one flit.
4. Owner deasserts req_valid for 2 cycles mid-packet while input 3 requests a head → pop=0 and sel stays on the owner for those 2 cycles. Input 3 is granted only after the owner's tail.
5. credits=8 with credit_in=1 → credits stays 8 and err_credit_ovf=1 from the next cycle. Separately, a send and a credit_in in the same cycle leave credits unchanged.
6. rst_n asserted in ACTIVE with credits=3 → immediately state=IDLE, credits=8, pop=0. After release, input 0 wins a tie against input 3.

Source files
------------

// File: rtl/router_pkg.sv
// router_pkg: shared router types, defaults and the round-robin pick helper
package router_pkg;
  localparam int NUM_PORTS       = 4;
  localparam int CREDITS_DEFAULT = 8;
  localparam int MAX_INPUTS      = 16;
  localparam int IDX_W           = $clog2(MAX_INPUTS);
  typedef enum logic {IDLE, ACTIVE} sched_state_t;
  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_t;
  function automatic rr_t rr_pick(input logic [MAX_INPUTS-1:0] cand, input logic [IDX_W-1:0] last, input int n);
    rr_t r;
    int j;
    logic [MAX_INPUTS-1:0] s;
    r = '{found: 1'b0, idx: '0};
    for (int k = 1; k <= MAX_INPUTS; k++) begin
      j = (int'(last) + k) % n;
      s = cand >> j;
      if (k <= n && !r.found && s[0]) begin
        r.found = 1'b1;
        r.idx   = IDX_W'(j);
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/router_credit_counter.sv
// router_credit_counter: downstream credit tracking with saturation and sticky overflow flag
//   consume   : a flit is sent this cycle (costs one credit)
//   credit_in : downstream freed one slot this cycle
//   credits   : registered credit count; can_send = credits != 0
//   err_ovf   : sticky, credit returned while already full
module router_credit_counter #(
  parameter int CREDITS  = 8,
  parameter int CREDIT_W = $clog2(CREDITS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                consume,
  input  logic                credit_in,
  output logic [CREDIT_W-1:0] credits,
  output logic                can_send,
  output logic                err_ovf
);
  logic [CREDIT_W-1:0] credits_q, credits_d;
  logic err_q, ovf;
  always_comb begin
    ovf       = credit_in && !consume && credits_q == CREDIT_W'(CREDITS);
    credits_d = ovf ? credits_q : credits_q + CREDIT_W'(credit_in) - CREDIT_W'(consume);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_q <= CREDIT_W'(CREDITS);
      err_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      err_q     <= err_q | ovf;
    end
  end
  assign credits  = credits_q;
  assign can_send = credits_q != '0;
  assign err_ovf  = err_q;
endmodule

// File: rtl/router_output_scheduler.sv
// router_output_scheduler: round-robin wormhole arbiter with credit flow control for one output port
//   req_valid/req_head/req_tail : per-input buffer-head status
//   credit_in                   : downstream slot freed
//   sel/pop/out_valid           : crossbar select, dequeue strobe, link valid (combinational)
//   credits/busy/err_credit_ovf : credit count, packet lock held, sticky credit overflow
module router_output_scheduler
  import router_pkg::*;
#(
  parameter int NUM_INPUTS = NUM_PORTS,
  parameter int CREDITS    = CREDITS_DEFAULT,
  parameter int CREDIT_W   = $clog2(CREDITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_INPUTS-1:0] req_valid,
  input  logic [NUM_INPUTS-1:0] req_head,
  input  logic [NUM_INPUTS-1:0] req_tail,
  input  logic                  credit_in,
  output logic [NUM_INPUTS-1:0] sel,
  output logic [NUM_INPUTS-1:0] pop,
  output logic                  out_valid,
  output logic [CREDIT_W-1:0]   credits,
  output logic                  busy,
  output logic                  err_credit_ovf
);
  sched_state_t state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d, last_q, last_d;
  logic [NUM_INPUTS-1:0] sel_c, pop_c;
  logic [MAX_INPUTS-1:0] cand;
  logic can_send, tail_w;
  rr_t pick;
  router_credit_counter #(.CREDITS(CREDITS), .CREDIT_W(CREDIT_W)) u_credit (
    .clk      (clk),
    .rst_n    (rst_n),
    .consume  (out_valid),
    .credit_in(credit_in),
    .credits  (credits),
    .can_send (can_send),
    .err_ovf  (err_credit_ovf)
  );
  always_comb begin
    cand    = MAX_INPUTS'(req_valid & req_head);
    pick    = rr_pick(cand, last_q, NUM_INPUTS);
    sel_c   = '0;
    pop_c   = '0;
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    if (state_q == IDLE) begin
      sel_c  = pick.found ? NUM_INPUTS'(1) << pick.idx : '0;
      tail_w = |(req_tail & sel_c);
      if (pick.found && can_send) begin
        pop_c   = sel_c;
        state_d = tail_w ? IDLE : ACTIVE;
        owner_d = tail_w ? owner_q : pick.idx;
        last_d  = tail_w ? pick.idx : last_q;
      end
    end else begin
      sel_c  = NUM_INPUTS'(1) << owner_q;
      tail_w = |(req_tail & sel_c);
      if (|(req_valid & sel_c) && can_send) begin
        pop_c   = sel_c;
        state_d = tail_w ? IDLE : ACTIVE;
        last_d  = tail_w ? owner_q : last_q;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_INPUTS - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end
  assign sel       = rst_n ? sel_c : '0;
  assign pop       = rst_n ? pop_c : '0;
  assign out_valid = |pop;
  assign busy      = state_q == ACTIVE;
endmodule

// File: tb/tb_router_output_scheduler.sv
// tb_router_output_scheduler: directed scoreboard bench for the output scheduler
module tb_router_output_scheduler;
  logic clk = 1'b0, rst_n = 1'b0, credit_in = 1'b0;
  logic [3:0] req_valid = '0, req_head = '0, req_tail = '0;
  logic [3:0] sel, pop, credits;
  logic out_valid, busy, err_credit_ovf;
  logic [7:0] exp_q[$];
  logic [7:0] e;
  int vecs = 0, errs = 0;

  router_output_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_head      (req_head),
    .req_tail      (req_tail),
    .credit_in     (credit_in),
    .sel           (sel),
    .pop           (pop),
    .out_valid     (out_valid),
    .credits       (credits),
    .busy          (busy),
    .err_credit_ovf(err_credit_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] x);
    vecs++;
    if (a !== x) begin
      errs++;
      $display("FAIL %s got %h want %h at %0t", n, a, x, $time);
    end
  endtask

  // one cycle: drive inputs, queue the expected transfer, check sel/bubble/credits/busy
  task automatic cyc(input logic [3:0] v, input logic [3:0] h, input logic [3:0] t, input logic ci,
                     input logic [3:0] esel, input logic [3:0] epop, input logic [3:0] ecr, input logic ebusy);
    @(posedge clk);
    #1;
    req_valid = v;
    req_head  = h;
    req_tail  = t;
    credit_in = ci;
    if (epop != 0) exp_q.push_back({epop, ecr});
    #2;
    chk("sel", 8'(sel), 8'(esel));
    if (epop == 0) chk("bubble_pop", {3'b0, out_valid, pop}, 8'h00);
    chk("credits", 8'(credits), 8'(ecr));
    chk("busy", 8'(busy), 8'(ebusy));
  endtask

  task automatic refill(input int start, input int n);
    for (int i = 0; i < n; i++) cyc(4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'(start + i), 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      vecs++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_pop got pop=%b credits=%0d want none", pop, credits);
      end else begin
        e = exp_q.pop_front();
        if ({pop, credits} !== e) begin
          errs++;
          $display("FAIL transfer got pop=%b credits=%0d want pop=%b credits=%0d", pop, credits, e[7:4], e[3:0]);
        end
      end
    end
  end

  initial begin
    #2;
    req_valid = 4'hF;
    req_head  = 4'hF;
    req_tail  = 4'hF;
    #1;
    chk("reset_sel", 8'(sel), 8'h00);
    chk("reset_pop", {3'b0, out_valid, pop}, 8'h00);
    req_valid = '0;
    req_head  = '0;
    req_tail  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("reset_credits", 8'(credits), 8'd8);
    chk("reset_busy", 8'(busy), 8'h00);
    chk("reset_err", 8'(err_credit_ovf), 8'h00);
    // round-robin over single-flit packets
    cyc(4'hF, 4'hF, 4'hF, 1'b0, 4'h1, 4'h1, 4'd8, 1'b0);
    cyc(4'hF, 4'hF, 4'hF, 1'b0, 4'h2, 4'h2, 4'd7, 1'b0);
    cyc(4'hF, 4'hF, 4'hF, 1'b0, 4'h4, 4'h4, 4'd6, 1'b0);
    cyc(4'hF, 4'hF, 4'hF, 1'b0, 4'h8, 4'h8, 4'd5, 1'b0);
    cyc(4'hF, 4'hF, 4'hF, 1'b0, 4'h1, 4'h1, 4'd4, 1'b0);
    cyc(4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'd3, 1'b0);
    refill(3, 5);
    // 5-flit packet from input 2 with input 0 head pending
    cyc(4'h5, 4'h5, 4'h0, 1'b0, 4'h4, 4'h4, 4'd8, 1'b0);
    for (int i = 0; i < 3; i++) cyc(4'h5, 4'h1, 4'h0, 1'b0, 4'h4, 4'h4, 4'(7 - i), 1'b1);
    cyc(4'h5, 4'h1, 4'h4, 1'b0, 4'h4, 4'h4, 4'd4, 1'b1);
    cyc(4'h1, 4'h1, 4'h1, 1'b0, 4'h1, 4'h1, 4'd3, 1'b0);
    refill(2, 6);
    // credit exhaustion on a 10-flit packet from input 1
    cyc(4'h2, 4'h2, 4'h0, 1'b0, 4'h2, 4'h2, 4'd8, 1'b0);
    for (int i = 0; i < 7; i++) cyc(4'h2, 4'h0, 4'h0, 1'b0, 4'h2, 4'h2, 4'(7 - i), 1'b1);
    cyc(4'h2, 4'h0, 4'h0, 1'b0, 4'h2, 4'h0, 4'd0, 1'b1);
    cyc(4'h2, 4'h0, 4'h0, 1'b1, 4'h2, 4'h0, 4'd0, 1'b1);
    cyc(4'h2, 4'h0, 4'h0, 1'b0, 4'h2, 4'h2, 4'd1, 1'b1);
    cyc(4'h2, 4'h0, 4'h2, 1'b1, 4'h2, 4'h0, 4'd0, 1'b1);
    cyc(4'h2, 4'h0, 4'h2, 1'b0, 4'h2, 4'h2, 4'd1, 1'b1);
    refill(0, 8);
    // owner 0 stalls while input 3 waits with a head
    cyc(4'h1, 4'h1, 4'h0, 1'b0, 4'h1, 4'h1, 4'd8, 1'b0);
    cyc(4'h1, 4'h0, 4'h0, 1'b0, 4'h1, 4'h1, 4'd7, 1'b1);
    cyc(4'h8, 4'h8, 4'h8, 1'b0, 4'h1, 4'h0, 4'd6, 1'b1);
    cyc(4'h8, 4'h8, 4'h8, 1'b0, 4'h1, 4'h0, 4'd6, 1'b1);
    cyc(4'h9, 4'h8, 4'h9, 1'b0, 4'h1, 4'h1, 4'd6, 1'b1);
    cyc(4'h8, 4'h8, 4'h8, 1'b0, 4'h8, 4'h8, 4'd5, 1'b0);
    refill(4, 4);
    // credit overflow is sticky; send plus credit keeps count
    cyc(4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'd8, 1'b0);
    chk("err_before", 8'(err_credit_ovf), 8'h00);
    cyc(4'h1, 4'h1, 4'h1, 1'b1, 4'h1, 4'h1, 4'd8, 1'b0);
    chk("err_set", 8'(err_credit_ovf), 8'h01);
    cyc(4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'd8, 1'b0);
    chk("err_sticky", 8'(err_credit_ovf), 8'h01);
    // reset mid-packet with 3 credits left
    cyc(4'h2, 4'h2, 4'h0, 1'b0, 4'h2, 4'h2, 4'd8, 1'b0);
    for (int i = 0; i < 4; i++) cyc(4'h2, 4'h0, 4'h0, 1'b0, 4'h2, 4'h2, 4'(7 - i), 1'b1);
    @(posedge clk);
    #1;
    req_valid = 4'h2;
    req_head  = 4'h0;
    chk("pre_reset_credits", 8'(credits), 8'd3);
    rst_n = 1'b0;
    #1;
    chk("rst_pop", {3'b0, out_valid, pop}, 8'h00);
    chk("rst_sel", 8'(sel), 8'h00);
    chk("rst_credits", 8'(credits), 8'd8);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_err", 8'(err_credit_ovf), 8'h00);
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(4'h9, 4'h9, 4'h9, 1'b0, 4'h1, 4'h1, 4'd8, 1'b0);
    cyc(4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'd7, 1'b0);
    chk("drain", 8'(exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
